// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: run-controller bus; master = harness/CPU side (drives pc, pc_valid), slave = controller (drives cpu_reset, cycle, running, done, halted, timeout)
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc;
  logic pc_valid;
  logic cpu_reset;
  logic [CNT_W-1:0] cycle;
  logic running;
  logic done;
  logic halted;
  logic timeout;
  modport master(output pc, pc_valid, input cpu_reset, cycle, running, done, halted, timeout);
  modport slave(input pc, pc_valid, output cpu_reset, cycle, running, done, halted, timeout);
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: CPU reset sequencer with power-on hold, one-shot reset injection, cycle count and halt/timeout end of run; ports clk, reset (async high), bus (slave: pc/pc_valid in; cpu_reset/cycle/running/done/halted/timeout out)
module cpu_run_ctrl #(
  parameter int CNT_W = 32,
  parameter int PC_W = 32,
  parameter int RST_CYCLES = 2,
  parameter int INJECT_AT = 11,
  parameter int INJ_CYCLES = 1,
  parameter int MAX_CYCLES = 100,
  parameter int HALT_REPEAT = 4
) (
  input logic clk,
  input logic reset,
  cpu_run_ctrl_if.slave bus
);
  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int ICW = $clog2(INJ_CYCLES + 1);
  localparam int RPW = $clog2(HALT_REPEAT + 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [ICW-1:0] INJ_LAST = ICW'(INJ_CYCLES - 1);
  localparam logic [RPW-1:0] REP_HALT = RPW'(HALT_REPEAT);
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] INJ_CYC = CNT_W'(INJECT_AT - 1);
  localparam logic INJ_EN = (INJECT_AT != 0);
  typedef enum logic [1:0] {RST, RUN, INJECT, DONE} state_t;
  state_t state, state_n;
  logic [RCW-1:0] rst_cnt, rst_cnt_n;
  logic [ICW-1:0] inj_cnt, inj_cnt_n;
  logic [RPW-1:0] rep, rep_n, rep_inc;
  logic [PC_W-1:0] last_pc, last_pc_n;
  logic injected, injected_n, have, have_n;
  logic pc_match, halt_hit, timeout_hit, inj_hit, active;
  assign active = (state == RUN) || (state == INJECT);
  assign rep_inc = rep + 1'b1;
  assign pc_match = bus.pc_valid && have && (bus.pc == last_pc);
  assign halt_hit = (state == RUN) && pc_match && (rep_inc == REP_HALT);
  assign timeout_hit = active && (bus.cycle == LAST_CYC);
  assign inj_hit = (state == RUN) && INJ_EN && !injected && (bus.cycle == INJ_CYC);
  always_comb begin
    state_n = state;
    rst_cnt_n = rst_cnt;
    inj_cnt_n = inj_cnt;
    injected_n = injected;
    have_n = have;
    last_pc_n = last_pc;
    rep_n = rep;
    case (state)
      RST: begin
        rst_cnt_n = rst_cnt + 1'b1;
        state_n = (rst_cnt == RST_LAST) ? RUN : RST;
      end
      RUN: begin
        if (bus.pc_valid) begin
          have_n = 1'b1;
          last_pc_n = bus.pc;
          rep_n = pc_match ? rep_inc : '0;
        end
        if (halt_hit || timeout_hit) state_n = DONE;
        else if (inj_hit) begin
          state_n = INJECT;
          injected_n = 1'b1;
          inj_cnt_n = '0;
          have_n = 1'b0;
          rep_n = '0;
        end
      end
      INJECT: begin
        have_n = 1'b0;
        rep_n = '0;
        inj_cnt_n = inj_cnt + 1'b1;
        state_n = timeout_hit ? DONE : (inj_cnt == INJ_LAST) ? RUN : INJECT;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST;
      rst_cnt <= '0;
      inj_cnt <= '0;
      injected <= 1'b0;
      have <= 1'b0;
      last_pc <= '0;
      rep <= '0;
      bus.cycle <= '0;
      bus.cpu_reset <= 1'b1;
      bus.running <= 1'b0;
      bus.done <= 1'b0;
      bus.halted <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      state <= state_n;
      rst_cnt <= rst_cnt_n;
      inj_cnt <= inj_cnt_n;
      injected <= injected_n;
      have <= have_n;
      last_pc <= last_pc_n;
      rep <= rep_n;
      bus.cycle <= active ? bus.cycle + 1'b1 : bus.cycle;
      bus.cpu_reset <= (state_n == RST) || (state_n == INJECT);
      bus.running <= (state_n == RUN) || (state_n == INJECT);
      bus.done <= (state_n == DONE);
      bus.halted <= bus.halted | halt_hit;
      bus.timeout <= bus.timeout | (timeout_hit & ~halt_hit);
    end
  end
endmodule
